// File: rtl/spram_bank_pkg.sv
// Package: spram_bank_pkg
// Purpose: shared constants, the scrub FSM state type and the bank-count
//          helper for the SPRAM bank array and its primitive wrapper.
// Contents:
//   SPRAM_ROW_BITS    address bits per SPRAM primitive (16K rows)
//   SPRAM_WIDTH       data width of one SPRAM primitive
//   UP5K_SPRAM_COUNT  number of SPRAM primitives on the device
//   state_e           S_CLEAR (scrubbing) / S_RUN (serving requests)
//   banks_for()       number of depth banks for a given word address width
package spram_bank_pkg;

    localparam int unsigned SPRAM_ROW_BITS   = 14;
    localparam int unsigned SPRAM_WIDTH      = 16;
    localparam int unsigned UP5K_SPRAM_COUNT = 4;

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_e;

    // Every address bit above the primitive row bits doubles the bank count.
    function automatic int unsigned banks_for(input int unsigned addr_width);
        if (addr_width < SPRAM_ROW_BITS) begin
            return 32'd1;
        end else begin
            return 32'd1 << (addr_width - SPRAM_ROW_BITS);
        end
    endfunction

endpackage

// File: rtl/single_port_ram_lattice_16Kx16.sv
// Module: single_port_ram_lattice_16Kx16
// Purpose: behavioural stand-in for one UP5K 16Kx16 SPRAM primitive with
//          byte write enables and a registered, read-enabled output.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset (output register only)
//   addr     in   14-bit row address
//   wdata    in   16-bit write data
//   we       in   byte write enables, we[1] = upper byte
//   re       in   read enable; rdata only changes on a read
//   rdata    out  registered read data, holds between reads
module single_port_ram_lattice_16Kx16
    import spram_bank_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [SPRAM_ROW_BITS-1:0] addr,
    input  logic [SPRAM_WIDTH-1:0]    wdata,
    input  logic [1:0]                we,
    input  logic                      re,
    output logic [SPRAM_WIDTH-1:0]    rdata
);

    logic [SPRAM_WIDTH-1:0] mem_q [2**SPRAM_ROW_BITS];
    logic [SPRAM_WIDTH-1:0] rdata_q;
    logic [SPRAM_WIDTH-1:0] rdata_d;

    // Storage array write port; memory contents are not reset.
    always_ff @(posedge clk) begin
        if (we[0]) begin
            mem_q[addr][7:0] <= wdata[7:0];
        end
        if (we[1]) begin
            mem_q[addr][15:8] <= wdata[15:8];
        end
    end

    // Output register only loads on a read so the bank mux can hold data.
    always_comb begin
        if (re) begin
            rdata_d = mem_q[addr];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Read data register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/spram_bank_array.sv
// Module: spram_bank_array
// Purpose: tiles 16Kx16 SPRAM primitives into BANKS (depth) x LANES (width),
//          serves a valid/ready request port with byte enables, returns read
//          data with fixed latency and scrubs the whole array to zero after
//          reset (optional) and on clear_req.
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake (ready only while not scrubbing)
//   req_we               byte write enables, all-zero means read
//   req_addr, req_wdata  word address and write data
//   rd_valid, rd_data    read return strobe and data (data holds otherwise)
//   clear_req            start a scrub (only honoured while running)
//   busy                 scrub in progress
module spram_bank_array
    import spram_bank_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 15,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter bit          OUTPUT_REG     = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [DATA_WIDTH/8-1:0] req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    rd_valid,
    output logic [DATA_WIDTH-1:0]   rd_data,
    input  logic                    clear_req,
    output logic                    busy
);

    localparam int unsigned BANKS     = banks_for(ADDR_WIDTH);
    localparam int unsigned LANES     = DATA_WIDTH / SPRAM_WIDTH;
    localparam int unsigned BANK_BITS = (ADDR_WIDTH > SPRAM_ROW_BITS) ? (ADDR_WIDTH - SPRAM_ROW_BITS) : 1;
    localparam logic [SPRAM_ROW_BITS-1:0] ROW_LAST = '1;
    localparam state_e RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_RUN;

    if (ADDR_WIDTH < SPRAM_ROW_BITS) begin : g_chk_aw
        $error("spram_bank_array: ADDR_WIDTH must be at least 14");
    end
    if ((DATA_WIDTH == 0) || ((DATA_WIDTH % SPRAM_WIDTH) != 0)) begin : g_chk_dw
        $error("spram_bank_array: DATA_WIDTH must be a non-zero multiple of 16");
    end
    if (BANKS * LANES > UP5K_SPRAM_COUNT) begin : g_chk_count
        $error("spram_bank_array: BANKS*LANES exceeds the UP5K SPRAM count");
    end

    state_e                    state_q, state_d;
    logic [SPRAM_ROW_BITS-1:0] scrub_cnt_q, scrub_cnt_d;
    logic                      busy_q, busy_d;
    logic                      ready_q, ready_d;
    logic                      rd_pend_q, rd_pend_d;
    logic [BANK_BITS-1:0]      bank_q, bank_d;

    logic                      accept_s;
    logic                      rd_accept_s;
    logic                      scrub_s;
    logic [BANK_BITS-1:0]      bank_s;
    logic [SPRAM_ROW_BITS-1:0] row_s;
    logic [BANKS-1:0][DATA_WIDTH-1:0] bank_rdata_s;
    logic [DATA_WIDTH-1:0]     rd_mux_s;

    assign accept_s    = req_valid & ready_q;
    assign rd_accept_s = accept_s & ~(|req_we);
    assign scrub_s     = (state_q == S_CLEAR);
    assign row_s       = req_addr[SPRAM_ROW_BITS-1:0];

    if (ADDR_WIDTH > SPRAM_ROW_BITS) begin : g_bank_dec
        assign bank_s = req_addr[ADDR_WIDTH-1:SPRAM_ROW_BITS];
    end else begin : g_one_bank
        assign bank_s = '0;
    end

    // While scrubbing every primitive is written with zero at the scrub row;
    // otherwise only the addressed bank sees enables.
    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            logic                      sel_s;
            logic [1:0]                lane_we_s;
            logic [SPRAM_ROW_BITS-1:0] lane_addr_s;
            logic [SPRAM_WIDTH-1:0]    lane_wdata_s;
            logic                      lane_re_s;

            assign sel_s        = accept_s && (bank_s == BANK_BITS'(b));
            assign lane_we_s    = scrub_s ? 2'b11 : (sel_s ? req_we[2*l +: 2] : 2'b00);
            assign lane_addr_s  = scrub_s ? scrub_cnt_q : row_s;
            assign lane_wdata_s = scrub_s ? 16'h0000 : req_wdata[SPRAM_WIDTH*l +: SPRAM_WIDTH];
            assign lane_re_s    = ~scrub_s & sel_s & ~(|req_we);

            single_port_ram_lattice_16Kx16 u_ram (
                .clk     (clk),
                .reset_n (reset_n),
                .addr    (lane_addr_s),
                .wdata   (lane_wdata_s),
                .we      (lane_we_s),
                .re      (lane_re_s),
                .rdata   (bank_rdata_s[b][SPRAM_WIDTH*l +: SPRAM_WIDTH])
            );
        end
    end

    // The bank captured with the read selects the returning data; both the
    // bank register and the primitive outputs hold, so rd_data holds too.
    assign rd_mux_s = bank_rdata_s[bank_q];

    // Scrub sequencer next state and registered status outputs.
    always_comb begin
        state_d     = state_q;
        scrub_cnt_d = scrub_cnt_q;
        case (state_q)
            S_CLEAR: begin
                if (scrub_cnt_q == ROW_LAST) begin
                    state_d     = S_RUN;
                    scrub_cnt_d = '0;
                end else begin
                    scrub_cnt_d = scrub_cnt_q + 14'd1;
                end
            end
            S_RUN: begin
                if (clear_req) begin
                    state_d     = S_CLEAR;
                    scrub_cnt_d = '0;
                end else begin
                    state_d     = S_RUN;
                end
            end
            default: begin
                state_d     = S_CLEAR;
                scrub_cnt_d = '0;
            end
        endcase
        busy_d    = (state_d == S_CLEAR);
        ready_d   = (state_d == S_RUN);
        rd_pend_d = rd_accept_s;
        if (rd_accept_s) begin
            bank_d = bank_s;
        end else begin
            bank_d = bank_q;
        end
    end

    // FSM, status and read-pipeline registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RESET_STATE;
            scrub_cnt_q <= '0;
            busy_q      <= CLEAR_ON_RESET;
            ready_q     <= 1'b0;
            rd_pend_q   <= 1'b0;
            bank_q      <= '0;
        end else begin
            state_q     <= state_d;
            scrub_cnt_q <= scrub_cnt_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            rd_pend_q   <= rd_pend_d;
            bank_q      <= bank_d;
        end
    end

    if (OUTPUT_REG) begin : g_out_reg
        logic                  rd_valid_q, rd_valid_d;
        logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

        // Extra output stage loads only when read data arrives.
        always_comb begin
            rd_valid_d = rd_pend_q;
            if (rd_pend_q) begin
                rd_data_d = rd_mux_s;
            end else begin
                rd_data_d = rd_data_q;
            end
        end

        // Output stage registers.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                rd_valid_q <= 1'b0;
                rd_data_q  <= '0;
            end else begin
                rd_valid_q <= rd_valid_d;
                rd_data_q  <= rd_data_d;
            end
        end

        assign rd_valid = rd_valid_q;
        assign rd_data  = rd_data_q;
    end else begin : g_out_direct
        assign rd_valid = rd_pend_q;
        assign rd_data  = rd_mux_s;
    end

    assign req_ready = ready_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_spram_bank_array.sv
// Testbench: tb_spram_bank_array
// Directed scenarios plus randomized traffic against a behavioural model
// (word array, scrub countdown, queue of expected read returns).
module tb_spram_bank_array;

    localparam int AW    = 15;
    localparam int DW    = 32;
    localparam bit CLR   = 1'b1;
    localparam bit OREG  = 1'b0;
    localparam int LAT   = OREG ? 2 : 1;
    localparam int SCRUB = 16384;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic [3:0]    req_we = 4'd0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          clear_req = 1'b0;
    logic          req_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          busy;

    always #5 clk = ~clk;

    spram_bank_array #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .CLEAR_ON_RESET (CLR),
        .OUTPUT_REG     (OREG)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .clear_req (clear_req),
        .busy      (busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_t;

    logic [31:0] m_mem [0:(2**AW)-1];
    int          m_clear_left;
    bit          m_ready;
    int          ecount = 0;
    rd_t         rdq[$];
    logic [31:0] m_last = 32'd0;

    task automatic zero_model();
        for (int i = 0; i < 2**AW; i++) m_mem[i] = 32'd0;
    endtask

    initial begin
        zero_model();
        m_clear_left = CLR ? SCRUB : 0;
        m_ready = 1'b0;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_clear_left = CLR ? SCRUB : 0;
                m_ready = 1'b0;
                rdq.delete();
                if (CLR) zero_model();
            end else begin
                if (m_ready && req_valid) begin
                    if (req_we != 4'd0) begin
                        for (int k = 0; k < 4; k++)
                            if (req_we[k]) m_mem[req_addr][8*k +: 8] = req_wdata[8*k +: 8];
                    end else begin
                        rdq.push_back('{due: ecount + LAT, data: m_mem[req_addr]});
                    end
                end
                if (m_clear_left > 0) begin
                    m_clear_left--;
                end else if (clear_req) begin
                    m_clear_left = SCRUB;
                    zero_model();
                end
                m_ready = (m_clear_left == 0);
                ecount++;
            end
        end
    end

    // Per-cycle compare of every output against the model.
    initial begin
        bit exp_v;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                m_last = 32'd0;
                check("rst_busy", {31'd0, busy}, {31'd0, CLR});
                check("rst_ready", {31'd0, req_ready}, 32'd0);
                check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
                check("rst_rd_data", rd_data, 32'd0);
            end else begin
                while (rdq.size() > 0 && rdq[0].due < ecount) void'(rdq.pop_front());
                exp_v = (rdq.size() > 0) && (rdq[0].due == ecount);
                check("cmp_busy", {31'd0, busy}, {31'd0, (m_clear_left > 0)});
                check("cmp_ready", {31'd0, req_ready}, {31'd0, m_ready});
                check("cmp_rd_valid", {31'd0, rd_valid}, {31'd0, exp_v});
                if (exp_v) begin
                    check("cmp_rd_data", rd_data, rdq[0].data);
                    m_last = rdq[0].data;
                    void'(rdq.pop_front());
                end else begin
                    check("cmp_rd_hold", rd_data, m_last);
                end
            end
        end
    end

    int rv_count = 0;
    initial forever begin
        @(negedge clk);
        if (rd_valid) rv_count++;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [3:0] we, input logic [AW-1:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 4'd0; clear_req = 1'b0;
    endtask

    task automatic wait_rd(input string name, input logic [31:0] exp);
        int lat = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (rd_valid) begin
                lat = i;
                break;
            end
        end
        check({name, "_lat"}, lat, LAT);
        check(name, rd_data, exp);
    endtask

    task automatic do_read(input string name, input logic [AW-1:0] addr, input logic [31:0] exp);
        issue(4'd0, addr, 32'd0);
        idle();
        wait_rd(name, exp);
    endtask

    task automatic measure_busy(output int n);
        n = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int rv0;
        logic [31:0] got [3];
        int cyc [3];
        int seen;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd1);
        check("reset_ready", {31'd0, req_ready}, 32'd0);
        check("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("reset_rd_data", rd_data, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        measure_busy(n);
        check("init_scrub_len", n, SCRUB);

        // Scrubbed array reads zero at the corners of both banks.
        do_read("t1_rd_0000", 15'h0000, 32'd0);
        do_read("t1_rd_3fff", 15'h3FFF, 32'd0);
        do_read("t1_rd_4000", 15'h4000, 32'd0);
        do_read("t1_rd_7fff", 15'h7FFF, 32'd0);

        // Write then read back-to-back, other bank untouched.
        issue(4'hF, 15'h4001, 32'h12345678);
        do_read("t2_rd_4001", 15'h4001, 32'h12345678);
        do_read("t2_rd_0001", 15'h0001, 32'd0);

        // Byte enables merge.
        issue(4'hF, 15'h0010, 32'hAABBCCDD);
        issue(4'b0101, 15'h0010, 32'h11223344);
        do_read("t3_byte_en", 15'h0010, 32'hAA22CC44);

        // Back-to-back reads across banks.
        issue(4'hF, 15'h0005, 32'h05050505);
        issue(4'hF, 15'h4005, 32'h40054005);
        issue(4'hF, 15'h0006, 32'h06060606);
        idle();
        seen = 0;
        fork
            begin
                issue(4'd0, 15'h0005, 32'd0);
                issue(4'd0, 15'h4005, 32'd0);
                issue(4'd0, 15'h0006, 32'd0);
                idle();
            end
            begin
                for (int c = 0; c < 10 && seen < 3; c++) begin
                    @(negedge clk);
                    if (rd_valid) begin
                        got[seen] = rd_data;
                        cyc[seen] = c;
                        seen++;
                    end
                end
            end
        join
        check("t4_count", seen, 3);
        if (seen == 3) begin
            check("t4_rd0", got[0], 32'h05050505);
            check("t4_rd1", got[1], 32'h40054005);
            check("t4_rd2", got[2], 32'h06060606);
            check("t4_consec1", cyc[1] - cyc[0], 1);
            check("t4_consec2", cyc[2] - cyc[1], 1);
        end

        // clear_req with a read in the same cycle; a second clear_req mid-scrub is ignored.
        issue(4'd0, 15'h4001, 32'd0);
        clear_req = 1'b1;
        idle();
        fork
            measure_busy(n);
            begin
                for (int i = 0; i < LAT; i++) @(negedge clk);
                check("t5_rd_valid", {31'd0, rd_valid}, 32'd1);
                check("t5_rd_old", rd_data, 32'h12345678);
            end
            begin
                repeat (100) @(posedge clk);
                #1 clear_req = 1'b1;
                @(posedge clk);
                #1 clear_req = 1'b0;
            end
        join
        check("t5_scrub_len", n, SCRUB);
        do_read("t5_rd_4001", 15'h4001, 32'd0);

        // Reset with a read pending, then again mid-scrub at row 0x2000.
        rv0 = rv_count;
        issue(4'd0, 15'h0005, 32'd0);
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1; req_valid = 1'b0;
        repeat (16'h2000) @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        measure_busy(n);
        check("t6_scrub_len", n, SCRUB);
        check("t6_no_rd_valid", rv_count - rv0, 0);
        do_read("t6_rd_0005", 15'h0005, 32'd0);

        // Randomized traffic on a few rows per bank so reads hit earlier writes.
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            req_valid = ($urandom_range(0, 3) != 0);
            req_addr  = AW'(($urandom_range(0, 1) << 14) | $urandom_range(0, 15));
            req_we    = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(0, 15));
            req_wdata = $urandom;
        end
        idle();
        repeat (5) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
